// File: rtl/fb_rect_writer.sv
// fb_rect_writer
//   Drawing engine on the write side of the video frame buffer. It accepts
//   rectangle-fill commands and clips each one to the screen. It then writes
//   the 12-bit color into every covered pixel in raster order, through a
//   write port that the memory arbiter gates with a grant.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   cmd_valid/ready   command handshake. A command transfers on a rising edge
//                     where cmd_valid && cmd_ready. cmd_ready is high only in
//                     IDLE, and the cmd_* fields are sampled on that edge only.
//   cmd_x0..cmd_y1    two inclusive corners, in either order
//   cmd_color         fill color {R[3:0],G[3:0],B[3:0]}
//   mem_we/addr/wdata write request. It is held stable until mem_grant is
//                     high on a rising edge, and that edge completes the write.
//   mem_grant         arbiter grant. It has no effect while mem_we is low.
//   busy              high whenever the FSM is not in IDLE
//   done              one-cycle pulse in the DONE state
module fb_rect_writer #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [X_W-1:0]    cmd_x0,
  input  logic [Y_W-1:0]    cmd_y0,
  input  logic [X_W-1:0]    cmd_x1,
  input  logic [Y_W-1:0]    cmd_y1,
  input  logic [11:0]       cmd_color,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [11:0]       mem_wdata,
  input  logic              mem_grant,
  output logic              busy,
  output logic              done
);

  localparam logic [X_W-1:0]    X_LAST   = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(V_RES - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLIP = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [X_W-1:0]      x0_q, x0_d, x1_q, x1_d;
  logic [Y_W-1:0]      y0_q, y0_d, y1_q, y1_d;
  logic [11:0]         color_q, color_d;
  logic [X_W-1:0]      xa_q, xa_d, xb_q, xb_d, x_q, x_d;
  logic [Y_W-1:0]      yb_q, yb_d, y_q, y_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;

  // Corner ordering of the latched command; used only in CLIP.
  logic [X_W-1:0] xa_c, xb_c;
  logic [Y_W-1:0] ya_c, yb_c;

  always_comb begin
    xa_c = (x0_q < x1_q) ? x0_q : x1_q;
    xb_c = (x0_q < x1_q) ? x1_q : x0_q;
    ya_c = (y0_q < y1_q) ? y0_q : y1_q;
    yb_c = (y0_q < y1_q) ? y1_q : y0_q;
  end

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    color_d    = color_q;
    xa_d       = xa_q;
    xb_d       = xb_q;
    yb_d       = yb_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          x0_d    = cmd_x0;
          y0_d    = cmd_y0;
          x1_d    = cmd_x1;
          y1_d    = cmd_y1;
          color_d = cmd_color;
          state_d = S_CLIP;
        end
      end
      S_CLIP: begin
        if (xa_c > X_LAST || ya_c > Y_LAST) begin
          state_d = S_DONE;
        end else begin
          xa_d       = xa_c;
          xb_d       = (xb_c > X_LAST) ? X_LAST : xb_c;
          yb_d       = (yb_c > Y_LAST) ? Y_LAST : yb_c;
          x_d        = xa_c;
          y_d        = ya_c;
          // Constant multiplier; this reduces to a shift-add.
          row_base_d = ADDR_W'(ya_c) * ROW_STEP;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        // mem_grant only advances the registered position. The address and
        // data outputs come from registers, so there is no grant-to-address
        // path.
        if (mem_grant) begin
          if (x_q < xb_q) begin
            x_d = x_q + X_W'(1);
          end else if (y_q < yb_q) begin
            x_d        = xa_q;
            y_d        = y_q + Y_W'(1);
            row_base_d = row_base_q + ROW_STEP;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
      xa_q       <= '0;
      xb_q       <= '0;
      yb_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      color_q    <= color_d;
      xa_q       <= xa_d;
      xb_q       <= xb_d;
      yb_q       <= yb_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_we    = (state_q == S_FILL);
  assign mem_addr  = row_base_q + ADDR_W'(x_q);
  assign mem_wdata = color_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
module tb_fb_rect_writer;

  localparam int H_RES  = 160;
  localparam int V_RES  = 120;
  localparam int X_W    = 8;
  localparam int Y_W    = 7;
  localparam int ADDR_W = 15;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [X_W-1:0]    cmd_x0, cmd_x1;
  logic [Y_W-1:0]    cmd_y0, cmd_y1;
  logic [11:0]       cmd_color;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [11:0]       mem_wdata;
  logic              mem_grant;
  logic              busy;
  logic              done;

  fb_rect_writer #(
    .H_RES(H_RES), .V_RES(V_RES), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x0   (cmd_x0),
    .cmd_y0   (cmd_y0),
    .cmd_x1   (cmd_x1),
    .cmd_y1   (cmd_y1),
    .cmd_color(cmd_color),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_grant(mem_grant),
    .busy     (busy),
    .done     (done)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [ADDR_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver: present a command at a negedge; it transfers on the next posedge
  task automatic accept(input logic [X_W-1:0] x0, input logic [Y_W-1:0] y0,
                        input logic [X_W-1:0] x1, input logic [Y_W-1:0] y1,
                        input logic [11:0] color);
    @(negedge clk);
    cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_color = color;
    cmd_valid = 1'b1;
    #1 chk("accept_ready", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Runs one command. Cycle k is the k-th clock period after the acceptance
  // edge. exp_q holds the expected accepted write addresses in order.
  task automatic run_cmd(input logic [X_W-1:0] x0, input logic [Y_W-1:0] y0,
                         input logic [X_W-1:0] x1, input logic [Y_W-1:0] y1,
                         input logic [11:0] color, input bit toggle, input bit junk,
                         input int exp_n, input int exp_done);
    int writes = 0;
    int first = -1;
    bit hold = 1'b0;
    bit fin = 1'b0;
    logic [ADDR_W-1:0] h_addr = '0;
    accept(x0, y0, x1, y1, color);
    if (junk) begin
      cmd_valid = 1'b1;
      cmd_x0 = 8'd50; cmd_y0 = 7'd50; cmd_x1 = 8'd60; cmd_y1 = 7'd60;
      cmd_color = 12'h123;
    end
    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      @(negedge clk);
      mem_grant = toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      if (cyc == 1) begin
        chk("clip_we", mem_we, 0);
        chk("clip_busy", busy, 1);
      end
      if (hold) begin
        chk("hold_we", mem_we, 1);
        chk("hold_addr", mem_addr, h_addr);
      end
      hold = mem_we && !mem_grant;
      h_addr = mem_addr;
      if (junk && busy) chk("busy_ready", cmd_ready, 0);
      if (mem_we && mem_grant) begin
        writes++;
        if (first < 0) first = cyc;
        if (exp_q.size() > 0) begin
          chk("wr_addr", mem_addr, exp_q.pop_front());
          chk("wr_data", mem_wdata, color);
        end else begin
          chk("extra_write", writes, exp_n);
        end
      end
      if (done) begin
        fin = 1'b1;
        chk("done_cycle", cyc, exp_done);
        chk("done_busy", busy, 1);
        chk("done_we", mem_we, 0);
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    chk("write_count", writes, exp_n);
    if (exp_n > 0) chk("first_write_cycle", first, 2);
    chk("exp_left", exp_q.size(), 0);
    exp_q.delete();
    cmd_valid = 1'b0;
    mem_grant = 1'b1;
    @(negedge clk);
    #1;
    chk("post_ready", cmd_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
    mem_grant = 1'b1;
    #22;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single pixel: 2*160+3 = 323, write in cycle 2, done in cycle 3
    exp_q.push_back(15'd323);
    run_cmd(8'd3, 7'd2, 8'd3, 7'd2, 12'hF00, 1'b0, 1'b0, 1, 3);

    // 3x2 block, cmd inputs held busy with junk; writes cycles 2..7, done 8
    exp_q.push_back(15'd0);   exp_q.push_back(15'd1);   exp_q.push_back(15'd2);
    exp_q.push_back(15'd160); exp_q.push_back(15'd161); exp_q.push_back(15'd162);
    run_cmd(8'd0, 7'd0, 8'd2, 7'd1, 12'h0F0, 1'b0, 1'b1, 6, 8);

    // same block, grant high only in even cycles: writes 2,4,..,12, done 13
    exp_q.push_back(15'd0);   exp_q.push_back(15'd1);   exp_q.push_back(15'd2);
    exp_q.push_back(15'd160); exp_q.push_back(15'd161); exp_q.push_back(15'd162);
    run_cmd(8'd0, 7'd0, 8'd2, 7'd1, 12'h0F0, 1'b1, 1'b0, 6, 13);

    // swapped corners: x 4..5, y 3..4 -> 3*160+4 = 484, 4*160+4 = 644
    exp_q.push_back(15'd484); exp_q.push_back(15'd485);
    exp_q.push_back(15'd644); exp_q.push_back(15'd645);
    run_cmd(8'd5, 7'd4, 8'd4, 7'd3, 12'h00F, 1'b0, 1'b0, 4, 6);

    // clipped to x 158..159, y 118..119: 118*160 = 18880, 119*160 = 19040
    exp_q.push_back(15'd19038); exp_q.push_back(15'd19039);
    exp_q.push_back(15'd19198); exp_q.push_back(15'd19199);
    run_cmd(8'd158, 7'd118, 8'd200, 7'd127, 12'hABC, 1'b0, 1'b0, 4, 6);

    // fully off-screen in x, then in y: no writes, done in cycle 2
    run_cmd(8'd160, 7'd0, 8'd165, 7'd5, 12'hFFF, 1'b0, 1'b0, 0, 2);
    run_cmd(8'd0, 7'd120, 8'd5, 7'd125, 12'hFFF, 1'b0, 1'b0, 0, 2);

    // reset in the middle of a 10x10 fill
    accept(8'd0, 7'd0, 8'd9, 7'd9, 12'h555);
    repeat (4) @(negedge clk);
    #1 chk("mid_fill_we", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_we", mem_we, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("after_rst_ready", cmd_ready, 1);
    chk("after_rst_we", mem_we, 0);
    chk("after_rst_addr", mem_addr, 0);

    // a new single pixel completes normally: 9*160+9 = 1449
    exp_q.push_back(15'd1449);
    run_cmd(8'd9, 7'd9, 8'd9, 7'd9, 12'h0F0, 1'b0, 1'b0, 1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
